// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered release of per-domain resets with ack handshake and timeout
//
// Releases N_STAGES reset domains one at a time, stage 0 first. All resets
// stay asserted for HOLD_CYC cycles after reset. Each released stage must then
// report ready on stage_done[k] (unless masked in ACK_MASK). After that, the
// next stage is released STAGE_DLY cycles later. A stage that does not report
// ready within TIMEOUT cycles re-asserts every domain and latches the error.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   soft_rst     single-cycle restart request, same effect as rst
//   stage_done   per-stage ready indication, synchronous to clk
//   rst_out      active-high reset per domain (registered)
//   seq_done     every stage released and acknowledged (registered)
//   timeout_err  sticky timeout flag (registered)
//   fail_stage   index of the stage that timed out, valid with timeout_err
//   busy         sequence in progress: HOLD, WAIT or SETTLE (registered)

module reset_sequencer #(
   parameter int                    N_STAGES  = 4,
   parameter int                    IDX_W     = 2,
   parameter int                    CNT_W     = 16,
   parameter int                    HOLD_CYC  = 16,
   parameter int                    STAGE_DLY = 8,
   parameter int                    TIMEOUT   = 1024,
   parameter logic [N_STAGES-1:0]   ACK_MASK  = {N_STAGES{1'b1}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                soft_rst,
   input  logic [N_STAGES-1:0] stage_done,
   output logic [N_STAGES-1:0] rst_out,
   output logic                seq_done,
   output logic                timeout_err,
   output logic [IDX_W-1:0]    fail_stage,
   output logic                busy
);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT,
      S_SETTLE,
      S_DONE,
      S_ERROR
   } state_t;

   // Limits are stored minus one so a limit of 2^CNT_W still fits the counter.
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STAGE_DLY - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_STAGE  = IDX_W'(N_STAGES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] stage;
   logic             stage_ok;

   // A masked stage counts as ready without looking at its input.
   assign stage_ok = stage_done[stage] | ~ACK_MASK[stage];

   always_ff @(posedge clk) begin
      if (rst || soft_rst) begin
         state       <= S_HOLD;
         cnt         <= '0;
         stage       <= '0;
         rst_out     <= '1;
         seq_done    <= 1'b0;
         timeout_err <= 1'b0;
         fail_stage  <= '0;
         busy        <= 1'b1;
      end else begin
         case (state)
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  rst_out[0] <= 1'b0;
                  stage      <= '0;
                  cnt        <= '0;
                  state      <= S_WAIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_WAIT: begin
               // Ready wins over timeout when both happen on the same edge.
               if (stage_ok) begin
                  cnt <= '0;
                  if (stage == LAST_STAGE) begin
                     seq_done <= 1'b1;
                     busy     <= 1'b0;
                     state    <= S_DONE;
                  end else begin
                     state <= S_SETTLE;
                  end
               end else if (cnt == WAIT_LAST) begin
                  rst_out     <= '1;
                  timeout_err <= 1'b1;
                  fail_stage  <= stage;
                  busy        <= 1'b0;
                  cnt         <= '0;
                  state       <= S_ERROR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  rst_out[stage + IDX_W'(1)] <= 1'b0;
                  stage                      <= stage + IDX_W'(1);
                  cnt                        <= '0;
                  state                      <= S_WAIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // Terminal states: only rst or soft_rst leave them.
            S_DONE: begin
               busy <= 1'b0;
            end

            S_ERROR: begin
               rst_out  <= '1;
               seq_done <= 1'b0;
               busy     <= 1'b0;
            end

            default: begin
               state   <= S_ERROR;
               rst_out <= '1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer

module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       soft_rst = 1'b0;
   logic [2:0] stage_done = 3'b000;

   logic [2:0] rst_out_a, rst_out_b;
   logic       seq_done_a, seq_done_b;
   logic       timeout_err_a, timeout_err_b;
   logic [1:0] fail_stage_a, fail_stage_b;
   logic       busy_a, busy_b;

   always #5 clk = ~clk;

   reset_sequencer #(
      .N_STAGES(3), .IDX_W(2), .CNT_W(16), .HOLD_CYC(8),
      .STAGE_DLY(4), .TIMEOUT(20), .ACK_MASK(3'b111)
   ) dut (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .stage_done(stage_done),
      .rst_out(rst_out_a), .seq_done(seq_done_a), .timeout_err(timeout_err_a),
      .fail_stage(fail_stage_a), .busy(busy_a)
   );

   reset_sequencer #(
      .N_STAGES(3), .IDX_W(2), .CNT_W(16), .HOLD_CYC(8),
      .STAGE_DLY(4), .TIMEOUT(20), .ACK_MASK(3'b101)
   ) dut_masked (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .stage_done(stage_done),
      .rst_out(rst_out_b), .seq_done(seq_done_b), .timeout_err(timeout_err_b),
      .fail_stage(fail_stage_b), .busy(busy_b)
   );

   // Expected output snapshot at a given edge (E1 = first edge after reset/soft_rst).
   typedef struct {
      int         edge_n;
      logic       sel;
      logic [2:0] ro;
      logic       sd;
      logic       te;
      logic [1:0] fs;
      logic       bz;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   e;
   int   checks = 0;
   int   failures = 0;

   function automatic logic [7:0] observed(input logic sel);
      if (sel)
         return {rst_out_b, seq_done_b, timeout_err_b, fail_stage_b, busy_b};
      return {rst_out_a, seq_done_a, timeout_err_a, fail_stage_a, busy_a};
   endfunction

   task automatic push(input int n, input logic sel, input logic [2:0] ro, input logic sd,
                       input logic te, input logic [1:0] fs, input logic bz, input string tag);
      exp_t x;
      x.edge_n = n; x.sel = sel; x.ro = ro; x.sd = sd;
      x.te = te; x.fs = fs; x.bz = bz; x.tag = tag;
      exp_q.push_back(x);
   endtask

   task automatic drain();
      exp_t       x;
      logic [7:0] obs, want;
      while (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
         x    = exp_q.pop_front();
         obs  = observed(x.sel);
         want = {x.ro, x.sd, x.te, x.fs, x.bz};
         checks++;
         assert (obs === want) else begin
            failures++;
            $error("FAIL %s edge=%0d {rst_out,seq_done,timeout_err,fail_stage,busy} got=%b want=%b",
                   x.tag, e, obs, want);
         end
      end
   endtask

   // One clock edge; sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
      e++;
      drain();
   endtask

   task automatic run_to(input int n);
      while (e < n) step();
   endtask

   // Apply rst or soft_rst for one edge; that edge becomes E0.
   task automatic restart(input logic use_soft);
      if (use_soft) soft_rst = 1'b1; else rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      soft_rst = 1'b0;
      e = 0;
      drain();
   endtask

   task automatic end_scenario(input string tag);
      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL %s_pending got=%0d want=0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      e = 0;

      // Nominal sequence.
      stage_done = 3'b111;
      push(0,  0, 3'b111, 0, 0, 0, 1, "nom_reset");
      push(7,  0, 3'b111, 0, 0, 0, 1, "nom_hold_e7");
      push(8,  0, 3'b110, 0, 0, 0, 1, "nom_rel0_e8");
      push(12, 0, 3'b110, 0, 0, 0, 1, "nom_settle_e12");
      push(13, 0, 3'b100, 0, 0, 0, 1, "nom_rel1_e13");
      push(17, 0, 3'b100, 0, 0, 0, 1, "nom_settle_e17");
      push(18, 0, 3'b000, 0, 0, 0, 1, "nom_rel2_e18");
      push(19, 0, 3'b000, 1, 0, 0, 0, "nom_done_e19");
      restart(1'b0);
      run_to(22);
      end_scenario("nom");

      // Masked stage 1 on the second instance.
      stage_done = 3'b101;
      push(0,  1, 3'b111, 0, 0, 0, 1, "msk_reset");
      push(8,  1, 3'b110, 0, 0, 0, 1, "msk_rel0_e8");
      push(13, 1, 3'b100, 0, 0, 0, 1, "msk_rel1_e13");
      push(18, 1, 3'b000, 0, 0, 0, 1, "msk_rel2_e18");
      push(19, 1, 3'b000, 1, 0, 0, 0, "msk_done_e19");
      restart(1'b0);
      run_to(20);
      end_scenario("msk");

      // Timeout on stage 1 (first instance requires its ack).
      stage_done = 3'b101;
      push(13, 0, 3'b100, 0, 0, 0, 1, "to_rel1_e13");
      push(32, 0, 3'b100, 0, 0, 0, 1, "to_wait_e32");
      push(33, 0, 3'b111, 0, 1, 1, 0, "to_err_e33");
      push(45, 0, 3'b111, 0, 1, 1, 0, "to_sticky_e45");
      restart(1'b0);
      run_to(45);
      end_scenario("to");

      // Recovery from ERROR via soft_rst.
      stage_done = 3'b111;
      push(0,  0, 3'b111, 0, 0, 0, 1, "rec_clear");
      push(18, 0, 3'b000, 0, 0, 0, 1, "rec_e18");
      push(19, 0, 3'b000, 1, 0, 0, 0, "rec_done_e19");
      restart(1'b1);
      run_to(19);
      end_scenario("rec");

      // Mid-sequence restart at E15.
      stage_done = 3'b111;
      push(14, 0, 3'b100, 0, 0, 0, 1, "mid_e14");
      restart(1'b0);
      run_to(14);
      end_scenario("mid_pre");
      push(0,  0, 3'b111, 0, 0, 0, 1, "mid_soft_e15");
      push(7,  0, 3'b111, 0, 0, 0, 1, "mid_hold_e22");
      push(8,  0, 3'b110, 0, 0, 0, 1, "mid_rel0_e23");
      push(13, 0, 3'b100, 0, 0, 0, 1, "mid_rel1_e28");
      restart(1'b1);
      run_to(13);
      end_scenario("mid");

      // Late ack on stage 2, then ack drop ignored in DONE.
      stage_done = 3'b011;
      push(18, 0, 3'b000, 0, 0, 0, 1, "late_rel2_e18");
      push(25, 0, 3'b000, 0, 0, 0, 1, "late_wait_e25");
      push(26, 0, 3'b000, 1, 0, 0, 0, "late_done_e26");
      push(40, 0, 3'b000, 1, 0, 0, 0, "late_hold_e40");
      restart(1'b0);
      run_to(25);
      stage_done = 3'b111;
      step();
      stage_done = 3'b000;
      run_to(40);
      end_scenario("late");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
